// File: rtl/sim_uart_rx_pkg.sv
// Shared definitions for the simulator console receive reader: register offsets,
// STATUS/CTRL bit positions and the width helper for FIFO pointers and counts.
package sim_uart_rx_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   localparam int DATA_VALID    = 8;
   localparam int ST_NOT_EMPTY  = 0;
   localparam int ST_FULL       = 1;
   localparam int ST_OVERRUN    = 2;
   localparam int ST_COUNT_LSB  = 8;
   localparam int ST_COUNT_W    = 8;
   localparam int CTRL_IRQ_EN   = 0;

   // Ceiling log2; log2c(16) = 4, log2c(17) = 5.
   function automatic int log2c(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sim_uart_rx_fifo.sv
// FIFO_DEPTH x 8 circular buffer; a push while full is accepted only when a pop
// retires the head in the same cycle.
module sim_uart_rx_fifo
   import sim_uart_rx_pkg::*;
#(
   parameter  int FIFO_DEPTH = 16,
   localparam int PTR_W      = log2c(FIFO_DEPTH),
   localparam int CNT_W      = log2c(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_nxt,
   output logic             empty,
   output logic             full
);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   // Pointers are exactly log2(FIFO_DEPTH) bits so they wrap without compare logic.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         count <= count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sim_uart_rx_reader.sv
// Wishbone character source: strobed bytes are queued and read through DATA/STATUS/CTRL.
// Define SIM_UART_RX_IRQ_EN to build the receive interrupt and the writable CTRL[0].
module sim_uart_rx_reader
   import sim_uart_rx_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int Dw         = 32,
   parameter int S_Aw       = 7,
   parameter int TAGw       = 3,
   parameter int SELw       = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [Dw-1:0]   s_dat_i,
   input  logic [SELw-1:0] s_sel_i,
   input  logic [S_Aw-1:0] s_addr_i,
   input  logic [TAGw-1:0] s_cti_i,
   input  logic            s_stb_i,
   input  logic            s_cyc_i,
   input  logic            s_we_i,
   output logic [Dw-1:0]   s_dat_o,
   output logic            s_ack_o,
   input  logic [7:0]      rx_dat_i,
   input  logic            rx_stb_i,
   output logic            irq_o
);

   localparam int CNT_W = log2c(FIFO_DEPTH + 1);

   logic             access_p0;
   logic             rd_p0;
   logic             wr_p0;
   logic [1:0]       reg_sel;
   logic             pop_p0;
   logic             ovr_clr;
   logic             drop;
   logic             overrun;
   logic             overrun_nxt;
   logic             irq_en;
   logic [Dw-1:0]    rd_word;
   logic [7:0]       fifo_dout;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] fifo_count_nxt;
   logic             fifo_empty;
   logic             fifo_full;
   logic             unused_ok;

   assign unused_ok = ^{s_sel_i, s_cti_i, s_addr_i, s_dat_i, fifo_count_nxt};

   // Decode only in the cycle the ack is being raised, so each access commits once.
   assign access_p0 = s_stb_i & s_cyc_i & ~s_ack_o;
   assign rd_p0     = access_p0 & ~s_we_i;
   assign wr_p0     = access_p0 & s_we_i;
   assign reg_sel   = s_addr_i[1:0];
   assign pop_p0    = rd_p0 & (reg_sel == REG_DATA);
   assign ovr_clr   = wr_p0 & (reg_sel == REG_STATUS) & s_dat_i[ST_OVERRUN];

   // A full FIFO is never empty, so any pop in this cycle frees a slot.
   assign drop        = rx_stb_i & fifo_full & ~pop_p0;
   assign overrun_nxt = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun);

   sim_uart_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_stb_i),
      .pop       (pop_p0),
      .din       (rx_dat_i),
      .dout      (fifo_dout),
      .count     (fifo_count),
      .count_nxt (fifo_count_nxt),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_comb begin
      rd_word = '0;
      case (reg_sel)
         REG_DATA: begin
            rd_word[7:0]       = fifo_empty ? 8'h00 : fifo_dout;
            rd_word[DATA_VALID] = ~fifo_empty;
         end
         REG_STATUS: begin
            rd_word[ST_NOT_EMPTY]                = ~fifo_empty;
            rd_word[ST_FULL]                     = fifo_full;
            rd_word[ST_OVERRUN]                  = overrun;
            rd_word[ST_COUNT_LSB +: ST_COUNT_W]  = ST_COUNT_W'(fifo_count);
         end
         REG_CTRL:  rd_word[CTRL_IRQ_EN] = irq_en;
         default:   rd_word = '0;
      endcase
   end

   // Bus response: one wait state, one-cycle ack, read data held until the next read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_ack_o <= 1'b0;
         s_dat_o <= '0;
         overrun <= 1'b0;
      end else begin
         s_ack_o <= access_p0;
         if (rd_p0) s_dat_o <= rd_word;
         overrun <= overrun_nxt;
      end
   end

`ifdef SIM_UART_RX_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_en <= 1'b0;
         irq_o  <= 1'b0;
      end else begin
         if (wr_p0 && (reg_sel == REG_CTRL)) irq_en <= s_dat_i[CTRL_IRQ_EN];
         irq_o <= irq_en & ((fifo_count_nxt != '0) | overrun_nxt);
      end
   end
`else
   assign irq_en = 1'b0;
   assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sim_uart_rx_reader.sv
// Scoreboard bench for sim_uart_rx_reader: a byte-queue model predicts every read.
module tb_sim_uart_rx_reader;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] s_dat_i = '0;
   logic [3:0]  s_sel_i = 4'hF;
   logic [6:0]  s_addr_i = '0;
   logic [2:0]  s_cti_i = '0;
   logic        s_stb_i = 1'b0;
   logic        s_cyc_i = 1'b0;
   logic        s_we_i = 1'b0;
   logic [31:0] s_dat_o;
   logic        s_ack_o;
   logic [7:0]  rx_dat_i = '0;
   logic        rx_stb_i = 1'b0;
   logic        irq_o;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] exp_q[$];
   logic [7:0]  mdl_q[$];
   bit          mdl_ov = 0;
   bit          mdl_irq_en = 0;

   sim_uart_rx_reader #(
      .FIFO_DEPTH(DEPTH), .Dw(32), .S_Aw(7), .TAGw(3), .SELw(4)
   ) dut (
      .clk(clk), .reset(reset), .s_dat_i(s_dat_i), .s_sel_i(s_sel_i),
      .s_addr_i(s_addr_i), .s_cti_i(s_cti_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
      .s_we_i(s_we_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .rx_dat_i(rx_dat_i),
      .rx_stb_i(rx_stb_i), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_read(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0: if (mdl_q.size() > 0) r = {23'b0, 1'b1, mdl_q[0]};
         2'd1: r = {16'b0, 8'(mdl_q.size()), 5'b0, mdl_ov,
                    1'(mdl_q.size() == DEPTH), 1'(mdl_q.size() != 0)};
         2'd2: r = {31'b0, mdl_irq_en};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic model_irq();
      return mdl_irq_en & ((mdl_q.size() != 0) | mdl_ov);
   endfunction

   task automatic model_push(input logic [7:0] b);
      if (mdl_q.size() < DEPTH) mdl_q.push_back(b);
      else mdl_ov = 1;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      @(negedge clk);
      rx_stb_i = 1'b1;
      rx_dat_i = b;
      @(negedge clk);
      rx_stb_i = 1'b0;
      model_push(b);
   endtask

   task automatic bus_read(input logic [1:0] a, input string name,
                           input bit with_rx = 0, input logic [7:0] rx_b = 8'h00);
      logic [31:0] e;
      bit got;
      exp_q.push_back(model_read(a));
      if (a == 2'd0 && mdl_q.size() > 0) void'(mdl_q.pop_front());
      if (with_rx) model_push(rx_b);
      @(negedge clk);
      s_addr_i = 7'(a);
      s_we_i   = 1'b0;
      s_stb_i  = 1'b1;
      s_cyc_i  = 1'b1;
      if (with_rx) begin
         rx_stb_i = 1'b1;
         rx_dat_i = rx_b;
      end
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         rx_stb_i = 1'b0;
         if (s_ack_o) got = 1;
      end
      s_stb_i = 1'b0;
      s_cyc_i = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL %s: no ack within 8 cycles, expected read 0x%08h", name, e);
      end else if (s_dat_o !== e) begin
         tests_failed++;
         $display("FAIL %s: read 0x%08h, expected 0x%08h", name, s_dat_o, e);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input string name);
      bit got;
      if (a == 2'd1 && d[2]) mdl_ov = 0;
`ifdef SIM_UART_RX_IRQ_EN
      if (a == 2'd2) mdl_irq_en = d[0];
`endif
      @(negedge clk);
      s_addr_i = 7'(a);
      s_dat_i  = d;
      s_we_i   = 1'b1;
      s_stb_i  = 1'b1;
      s_cyc_i  = 1'b1;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (s_ack_o) got = 1;
      end
      s_stb_i = 1'b0;
      s_cyc_i = 1'b0;
      s_we_i  = 1'b0;
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL %s: write got no ack within 8 cycles", name);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({s_ack_o, irq_o, s_dat_o} !== 34'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ack=%b irq=%b dat=0x%08h, expected all 0",
                  s_ack_o, irq_o, s_dat_o);
      end
      reset = 1'b1;
      @(negedge clk);
      bus_read(2'd1, "reset_status");
      bus_read(2'd0, "reset_data_empty");
      bus_read(2'd1, "reset_status_after_empty_pop");
   endtask

   task automatic test_basic();
      rx_byte(8'h41);
      rx_byte(8'h42);
      bus_read(2'd0, "basic_data0");
      bus_read(2'd0, "basic_data1");
      bus_read(2'd1, "basic_status_empty");
   endtask

   task automatic test_overrun();
      for (int i = 0; i <= DEPTH; i++) rx_byte(8'(i));
      bus_read(2'd1, "ovr_status_full");
      for (int i = 0; i < DEPTH; i++) bus_read(2'd0, $sformatf("ovr_drain%0d", i));
      bus_read(2'd1, "ovr_status_sticky");
      bus_write(2'd1, 32'h4, "ovr_clear_write");
      bus_read(2'd1, "ovr_status_cleared");
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < DEPTH; i++) rx_byte(8'(i));
      bus_read(2'd0, "fpp_pop_with_push", 1'b1, 8'h55);
      bus_read(2'd1, "fpp_status_still_full");
      for (int i = 0; i < DEPTH; i++) bus_read(2'd0, $sformatf("fpp_drain%0d", i));
      bus_read(2'd1, "fpp_status_empty");
   endtask

   task automatic test_irq();
      rx_byte(8'h33);
      @(negedge clk);
      tests_run++;
      if (irq_o !== model_irq()) begin
         tests_failed++;
         $display("FAIL irq_disabled: irq_o=%b expected %b", irq_o, model_irq());
      end
      bus_write(2'd2, 32'h1, "irq_ctrl_write");
      tests_run++;
      if (irq_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL irq_at_ack: irq_o=%b expected 0", irq_o);
      end
      @(negedge clk);
      tests_run++;
      if (irq_o !== model_irq()) begin
         tests_failed++;
         $display("FAIL irq_after_ack: irq_o=%b expected %b", irq_o, model_irq());
      end
      bus_read(2'd2, "irq_ctrl_read");
      bus_read(2'd0, "irq_drain");
      @(negedge clk);
      tests_run++;
      if (irq_o !== model_irq()) begin
         tests_failed++;
         $display("FAIL irq_drained: irq_o=%b expected %b", irq_o, model_irq());
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i <= DEPTH; i++) rx_byte(8'(8'h80 + i));
      for (int i = 0; i < DEPTH - 5; i++) bus_read(2'd0, $sformatf("mid_drain%0d", i));
      bus_read(2'd1, "mid_status_count5_ovr");
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      tests_run++;
      if ({s_ack_o, irq_o, s_dat_o} !== 34'd0) begin
         tests_failed++;
         $display("FAIL mid_reset_async: ack=%b irq=%b dat=0x%08h, expected all 0",
                  s_ack_o, irq_o, s_dat_o);
      end
      mdl_q.delete();
      mdl_ov = 0;
      mdl_irq_en = 0;
      @(negedge clk);
      reset = 1'b1;
      bus_read(2'd1, "mid_status_after_reset");
      bus_read(2'd2, "mid_ctrl_after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_full_push_pop();
      test_irq();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sim_uart_rx_reader.md
# sim_uart_rx_reader

Wishbone-slave character source, the receive-side counterpart of the simulator console UART: bytes arriving on a strobe-only byte port are queued in a small FIFO and read by the processor through a three-register map. It sits on the peripheral bus next to the console UART. It gives software running in simulation, or a test harness, a way to feed characters back to the CPU.

## Interface
Parameters:
- FIFO_DEPTH, 16: receive FIFO entries; power of two, ≥2
- Dw, 32: wishbone data width
- S_Aw, 7: slave address width
- TAGw, 3: cti width
- SELw, 4: byte-select width

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- s_dat_i  in  Dw  write data
- s_sel_i  in  SELw  byte selects; ignored, whole-word access
- s_addr_i  in  S_Aw  word address; bits [1:0] decoded
- s_cti_i  in  TAGw  ignored
- s_stb_i, s_cyc_i, s_we_i  in  1 each  wishbone strobe/cycle/write
- s_dat_o  out  Dw  registered read data
- s_ack_o  out  1  registered acknowledge
- rx_dat_i  in  8  incoming byte
- rx_stb_i  in  1  one-cycle byte strobe; no backpressure
- irq_o  out  1  receive interrupt

## Operation
- Register map, by s_addr_i[1:0]:
  - 0 DATA (read): [7:0] FIFO head, [8] valid. A read pops one entry when the FIFO is non-empty.
  - 1 STATUS: [0] not_empty, [1] full, [2] overrun (sticky), [15:8] count, zero-extended. Writing 1 to bit 2 clears overrun.
  - 2 CTRL: [0] irq_en (R/W).
  - 3: reads 0; writes ignored.
- Writes to DATA are ignored.
- Push: on rx_stb_i when not full, or when full with a pop in the same cycle. Otherwise the byte is dropped and overrun is set.
- Pop of an empty FIFO: DATA returns 0x000, valid = 0, and pointers/count are unchanged.
- Push and pop in the same cycle: count is unchanged; the popped value is the old head.
- count width = log2(FIFO_DEPTH+1); pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Overrun clear and a new overrun in the same cycle: the set wins.

## Timing
- Reset values, all asynchronous on reset low:
  - s_ack_o = 0, s_dat_o = 0, irq_o = 0
  - pointers = 0, count = 0
  - overrun = 0, irq_en = 0
- Ack: s_ack_o ← s_stb_i & s_cyc_i & ~s_ack_o. This gives one wait state and a one-cycle ack pulse per access, so back-to-back accesses ack every other cycle.
- Access decode happens in the cycle where the ack is being raised:
  - s_dat_o is loaded on that same edge.
  - The pop or register write commits on that same edge.
  - Exactly one pop per read transaction.
- s_dat_o holds its value until the next read.
- A byte pushed on edge N is visible in STATUS/DATA sampled at edge N+1.
- Reset deasserting mid-transaction: the bus transaction is restarted by the master, and the block starts from the empty state.

## Configuration
- SIM_UART_RX_IRQ_EN defined:
  - irq_o is registered: irq_o ← irq_en & (not_empty_next | overrun_next).
  - CTRL[0] is writable.
- SIM_UART_RX_IRQ_EN undefined:
  - irq_o is tied to 0.
  - CTRL reads 0 and writes are ignored.
  - The irq_en flop is not built.

## Structure
- Package sim_uart_rx_pkg holds:
  - register offsets DATA/STATUS/CTRL
  - STATUS/CTRL bit positions
  - the log2 function for count/pointer widths
- One sub-module, sim_uart_rx_fifo: parameterised FIFO_DEPTH×8 circular buffer.
  - Inputs: push, pop, din.
  - Outputs: dout, count, empty, full.
  - It implements the full-with-simultaneous-pop acceptance rule.
- The top level holds the bus decode, ack, status/ctrl flops and irq.

## Test plan
- After reset, read STATUS → 0x00000000. Read DATA → 0x000, and the count stays 0.
- Strobe 0x41, 0x42, then read DATA twice → 0x141, then 0x142. STATUS then reads 0.
- Strobe 17 bytes 0x00..0x10 with FIFO_DEPTH=16:
  - STATUS → full, overrun, count 16 → 0x00001007.
  - Reads return 0x100..0x10F.
  - Write STATUS 0x4, and overrun clears.
- Fill to 16, then issue rx_stb_i with 0x55 in the same cycle as a DATA pop:
  - The pop returns 0x100, overrun stays 0, count stays 16.
  - The last read after draining returns 0x155.
- With SIM_UART_RX_IRQ_EN:
  - irq_en = 0 plus a byte → irq_o = 0.
  - Write CTRL = 1 → irq_o = 1 one cycle after the write ack.
  - Drain the FIFO → irq_o = 0.
  - Without the macro, irq_o stays 0 throughout.
- Assert reset mid-fill, with count 5 and overrun set → all outputs and STATUS return 0 immediately, before the next clk edge.
